// File: rtl/control_unit.sv
// control_unit
//
// Hardwired sequencer for ALUSystem. It steps through CLR, F0, F1, EX0, (EX1) and HALT,
// and drives every datapath control from the state register, IROut and an internal Z copy.
//
// Ports:
//   Clock, Reset            rising-edge clock, asynchronous active-high reset
//   IROut[15:0]             instruction: [15:12] opcode, [11:10] RD, [9:8] RS, [7:0] imm
//   ALUOutFlag[3:0]         {Z,C,N,O}; only Z is used, and only as next-state input
//   RF_*                    register-file selects (RF_RegSel is active low, bit3 = R1)
//   ALU_FunSel              0000 pass A, 0100 A+B, 0110 A-B
//   ARF_*                   address-register-file selects (ARF_RegSel active low {PC,AR,SP})
//   IR_LH/IR_Enable/IR_Funsel  instruction-register load controls
//   Mem_WR, Mem_CS          memory write strobe and active-low chip select
//   MuxASel/MuxBSel/MuxCSel datapath source muxes
//   Halted, State           status: State encodes CLR=0 F0=1 F1=2 EX0=3 EX1=4 HALT=5
module control_unit (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  ALUOutFlag,
    output logic [1:0]  RF_OutASel,
    output logic [1:0]  RF_OutBSel,
    output logic [1:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  ALU_FunSel,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [1:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Enable,
    output logic [1:0]  IR_Funsel,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic        Halted,
    output logic [2:0]  State
);

    typedef enum logic [2:0] {
        StClr  = 3'd0,
        StF0   = 3'd1,
        StF1   = 3'd2,
        StEx0  = 3'd3,
        StEx1  = 3'd4,
        StHalt = 3'd5
    } stateT;

    localparam logic [3:0] OpLdi = 4'h1;
    localparam logic [3:0] OpLd  = 4'h2;
    localparam logic [3:0] OpSt  = 4'h3;
    localparam logic [3:0] OpAdd = 4'h4;
    localparam logic [3:0] OpSub = 4'h5;
    localparam logic [3:0] OpBra = 4'h6;
    localparam logic [3:0] OpBne = 4'h7;
    localparam logic [3:0] OpHlt = 4'hF;

    stateT      stateQ, stateD;
    logic       zfQ, zfD;
    logic [3:0] opcode;
    logic [1:0] rd, rs;
    logic [3:0] rdEnN;

    assign opcode = IROut[15:12];
    assign rd     = IROut[11:10];
    assign rs     = IROut[9:8];
    // Active-low one-hot enable for RD: R1 sits on bit 3.
    assign rdEnN  = ~(4'b1000 >> rd);

    // The immediate is routed by the datapath, and only Z matters here.
    logic unusedBits;
    assign unusedBits = ^{IROut[7:0], ALUOutFlag[2:0]};

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            stateQ <= StClr;
            zfQ    <= 1'b0;
        end else begin
            stateQ <= stateD;
            zfQ    <= zfD;
        end
    end

    always_comb begin
        RF_OutASel  = 2'b00;
        RF_OutBSel  = 2'b00;
        RF_FunSel   = 2'b00;
        RF_RegSel   = 4'b1111;
        ALU_FunSel  = 4'b0000;
        ARF_OutCSel = 2'b00;
        ARF_OutDSel = 2'b00;
        ARF_FunSel  = 2'b00;
        ARF_RegSel  = 3'b111;
        IR_LH       = 1'b0;
        IR_Enable   = 1'b0;
        IR_Funsel   = 2'b00;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        MuxASel     = 2'b00;
        MuxBSel     = 2'b00;
        MuxCSel     = 1'b0;
        stateD      = stateQ;
        zfD         = zfQ;

        case (stateQ)
            StClr: begin
                RF_RegSel  = 4'b0000;
                RF_FunSel  = 2'b11;
                ARF_RegSel = 3'b000;
                ARF_FunSel = 2'b11;
                stateD     = StF0;
            end
            StF0, StF1: begin
                // IR byte <- M[PC] and PC++ on the same edge.
                ARF_OutDSel = 2'b00;
                Mem_CS      = 1'b0;
                IR_Enable   = 1'b1;
                IR_LH       = (stateQ == StF1);
                IR_Funsel   = 2'b10;
                ARF_RegSel  = 3'b011;
                ARF_FunSel  = 2'b01;
                stateD      = (stateQ == StF0) ? StF1 : StEx0;
            end
            StEx0, StEx1: begin
                stateD = StF0;
                case (opcode)
                    OpLdi: begin
                        MuxASel   = 2'b10;
                        RF_FunSel = 2'b10;
                        RF_RegSel = rdEnN;
                    end
                    OpLd, OpSt: begin
                        if (stateQ == StEx0) begin
                            // AR <- imm, memory access follows in EX1.
                            MuxBSel    = 2'b10;
                            ARF_FunSel = 2'b10;
                            ARF_RegSel = 3'b101;
                            stateD     = StEx1;
                        end else if (opcode == OpLd) begin
                            ARF_OutDSel = 2'b01;
                            Mem_CS      = 1'b0;
                            MuxASel     = 2'b01;
                            RF_FunSel   = 2'b10;
                            RF_RegSel   = rdEnN;
                        end else begin
                            // ALU passes RS through to the memory data input.
                            RF_OutASel  = rs;
                            ARF_OutDSel = 2'b01;
                            Mem_CS      = 1'b0;
                            Mem_WR      = 1'b1;
                        end
                    end
                    OpAdd, OpSub: begin
                        RF_OutASel = rd;
                        RF_OutBSel = rs;
                        ALU_FunSel = (opcode == OpAdd) ? 4'b0100 : 4'b0110;
                        MuxASel    = 2'b00;
                        RF_FunSel  = 2'b10;
                        RF_RegSel  = rdEnN;
                        zfD        = ALUOutFlag[3];
                    end
                    OpBra, OpBne: begin
                        if (opcode == OpBra || !zfQ) begin
                            MuxBSel    = 2'b10;
                            ARF_FunSel = 2'b10;
                            ARF_RegSel = 3'b011;
                        end
                    end
                    OpHlt: stateD = StHalt;
                    default: ;
                endcase
            end
            StHalt: stateD = StHalt;
            default: stateD = StClr;
        endcase
    end

    assign Halted = (stateQ == StHalt);
    assign State  = stateQ;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: wraps it in a behavioural ALUSystem datapath, runs small
// programs and compares a per-cycle expected trace (state, ALU function, write strobe, PC)
// queued when each program is set up.
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] IROut;
    logic [3:0]  ALUOutFlag;
    logic [1:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
    logic [3:0]  RF_RegSel, ALU_FunSel;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
    logic [2:0]  ARF_RegSel;
    logic        IR_LH, IR_Enable;
    logic [1:0]  IR_Funsel;
    logic        Mem_WR, Mem_CS;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel, Halted;
    logic [2:0]  State;

    control_unit dut (
        .Clock(Clock), .Reset(Reset), .IROut(IROut), .ALUOutFlag(ALUOutFlag),
        .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
        .RF_RegSel(RF_RegSel), .ALU_FunSel(ALU_FunSel), .ARF_OutCSel(ARF_OutCSel),
        .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
        .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel), .Mem_WR(Mem_WR),
        .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
        .Halted(Halted), .State(State)
    );

    always #5 Clock = ~Clock;

    // Behavioural datapath (registers deliberately have no reset).
    logic [7:0]  mem [256];
    logic [7:0]  prog [256];
    logic        loadReq = 1'b0;
    logic [7:0]  rf [4];
    logic [7:0]  pcR, arR, spR;
    logic [15:0] ir;
    logic [7:0]  aOut, bOut, cOut, dOut, memOut, aluA, aluOut, muxAOut, muxBOut;

    assign IROut = ir;
    assign aOut  = rf[RF_OutASel];
    assign bOut  = rf[RF_OutBSel];
    assign cOut  = (ARF_OutCSel == 2'b00) ? pcR : (ARF_OutCSel == 2'b01) ? arR : spR;
    assign dOut  = (ARF_OutDSel == 2'b00) ? pcR : (ARF_OutDSel == 2'b01) ? arR : spR;
    assign memOut = mem[dOut];
    assign aluA  = MuxCSel ? cOut : aOut;
    assign aluOut = (ALU_FunSel == 4'b0100) ? aluA + bOut :
                    (ALU_FunSel == 4'b0110) ? aluA - bOut : aluA;
    assign ALUOutFlag = {aluOut == 8'h00, 1'b0, aluOut[7], 1'b0};
    assign muxAOut = (MuxASel == 2'b00) ? aluOut : (MuxASel == 2'b01) ? memOut :
                     (MuxASel == 2'b10) ? ir[7:0] : cOut;
    assign muxBOut = (MuxBSel == 2'b00) ? aluOut : (MuxBSel == 2'b01) ? memOut :
                     (MuxBSel == 2'b10) ? ir[7:0] : cOut;

    function automatic logic [7:0] applyFun(input logic [1:0] f, input logic [7:0] cur,
                                            input logic [7:0] din);
        case (f)
            2'b00:   return cur - 8'd1;
            2'b01:   return cur + 8'd1;
            2'b10:   return din;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge Clock) begin
        if (loadReq) begin
            for (int i = 0; i < 256; i++) mem[i] <= prog[i];
        end else if (!Mem_CS && Mem_WR) begin
            mem[dOut] <= aluOut;
        end
        for (int i = 0; i < 4; i++)
            if (!RF_RegSel[3-i]) rf[i] <= applyFun(RF_FunSel, rf[i], muxAOut);
        if (!ARF_RegSel[2]) pcR <= applyFun(ARF_FunSel, pcR, muxBOut);
        if (!ARF_RegSel[1]) arR <= applyFun(ARF_FunSel, arR, muxBOut);
        if (!ARF_RegSel[0]) spR <= applyFun(ARF_FunSel, spR, muxBOut);
        if (IR_Enable) begin
            if (IR_Funsel == 2'b10) begin
                if (IR_LH) ir[15:8] <= memOut;
                else       ir[7:0]  <= memOut;
            end else if (IR_Funsel == 2'b11) begin
                ir <= 16'h0000;
            end
        end
    end

    // Scoreboard
    typedef struct {
        logic [2:0] st;
        logic [3:0] alu;
        logic       wr;
        logic [7:0] pc;
    } expT;
    expT expQ[$];

    int checks = 0;
    int errors = 0;

    task automatic checkEq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pushSt(input logic [2:0] st, input logic [7:0] pc);
        expT e;
        e.st = st; e.alu = 4'h0; e.wr = 1'b0; e.pc = pc;
        expQ.push_back(e);
    endtask

    // One instruction fetched at pc: F0, F1, EX0 and optionally EX1.
    task automatic pushInstr(input logic [7:0] pc, input logic [3:0] exAlu, input bit twoEx,
                             input bit stWr);
        expT e;
        pushSt(3'd1, pc);
        pushSt(3'd2, pc + 8'd1);
        e.st = 3'd3; e.alu = exAlu; e.wr = 1'b0; e.pc = pc + 8'd2;
        expQ.push_back(e);
        if (twoEx) begin
            e.st = 3'd4; e.alu = 4'h0; e.wr = stWr; e.pc = pc + 8'd2;
            expQ.push_back(e);
        end
    endtask

    task automatic clearProg();
        for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    endtask

    // Optionally loads memory and resets, then pops and compares one entry per cycle.
    // Returns in the middle of the last traced cycle.
    task automatic runProgram(input bit doReset);
        expT e;
        int  n;
        n = 0;
        if (doReset) begin
            @(negedge Clock);
            Reset   = 1'b1;
            loadReq = 1'b1;
            @(negedge Clock);
            loadReq = 1'b0;
            @(negedge Clock);
            Reset   = 1'b0;
        end
        #1;
        while (expQ.size() > 0) begin
            if (n != 0) begin
                @(negedge Clock);
                #1;
            end
            e = expQ.pop_front();
            checkEq($sformatf("state[%0d]", n), {13'd0, State}, {13'd0, e.st});
            checkEq($sformatf("aluFun[%0d]", n), {12'd0, ALU_FunSel}, {12'd0, e.alu});
            checkEq($sformatf("memWr[%0d]", n), {15'd0, Mem_WR}, {15'd0, e.wr});
            checkEq($sformatf("pc[%0d]", n), {8'd0, pcR}, {8'd0, e.pc});
            n++;
        end
    endtask

    initial begin
        // LDI R1,5 ; HLT, then 10 halted cycles with PC frozen
        clearProg();
        prog[0] = 8'h05; prog[1] = 8'h10; prog[2] = 8'h00; prog[3] = 8'hF0;
        pushSt(3'd0, 8'h00);
        pushInstr(8'h00, 4'h0, 1'b0, 1'b0);
        pushInstr(8'h02, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) pushSt(3'd5, 8'h04);
        runProgram(1'b1);
        checkEq("ldi_r1", {8'd0, rf[0]}, 16'h0005);
        checkEq("halted", {15'd0, Halted}, 16'h0001);
        checkEq("halt_rfRegSel", {12'd0, RF_RegSel}, 16'h000F);
        checkEq("halt_arfRegSel", {13'd0, ARF_RegSel}, 16'h0007);
        checkEq("halt_memCs", {15'd0, Mem_CS}, 16'h0001);

        // LDI R1,5 ; LDI R2,3 ; ADD R1,R2 ; BNE 0x10 (taken, zf=0) ; HLT at 0x10
        clearProg();
        prog[0] = 8'h05; prog[1] = 8'h10; prog[2] = 8'h03; prog[3] = 8'h14;
        prog[4] = 8'h00; prog[5] = 8'h41; prog[6] = 8'h10; prog[7] = 8'h70;
        prog[8'h10] = 8'h00; prog[8'h11] = 8'hF0;
        pushSt(3'd0, 8'h00);
        pushInstr(8'h00, 4'h0, 1'b0, 1'b0);
        pushInstr(8'h02, 4'h0, 1'b0, 1'b0);
        pushInstr(8'h04, 4'h4, 1'b0, 1'b0);
        pushInstr(8'h06, 4'h0, 1'b0, 1'b0);
        pushInstr(8'h10, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) pushSt(3'd5, 8'h12);
        runProgram(1'b1);
        checkEq("add_r1", {8'd0, rf[0]}, 16'h0008);
        checkEq("add_r2", {8'd0, rf[1]}, 16'h0003);

        // LDI R1,3 ; LDI R2,3 ; SUB R1,R2 ; BNE 0 (not taken) ; BRA 0x20 ; HLT at 0x20
        clearProg();
        prog[0] = 8'h03; prog[1] = 8'h10; prog[2] = 8'h03; prog[3] = 8'h14;
        prog[4] = 8'h00; prog[5] = 8'h51; prog[6] = 8'h00; prog[7] = 8'h70;
        prog[8] = 8'h20; prog[9] = 8'h60;
        prog[8'h20] = 8'h00; prog[8'h21] = 8'hF0;
        pushSt(3'd0, 8'h00);
        pushInstr(8'h00, 4'h0, 1'b0, 1'b0);
        pushInstr(8'h02, 4'h0, 1'b0, 1'b0);
        pushInstr(8'h04, 4'h6, 1'b0, 1'b0);
        pushInstr(8'h06, 4'h0, 1'b0, 1'b0);
        pushInstr(8'h08, 4'h0, 1'b0, 1'b0);
        pushInstr(8'h20, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) pushSt(3'd5, 8'h22);
        runProgram(1'b1);
        checkEq("sub_r1", {8'd0, rf[0]}, 16'h0000);

        // LDI R1,0x5A ; ST R1,[0x80] ; LD R3,[0x80] ; HLT
        clearProg();
        prog[0] = 8'h5A; prog[1] = 8'h10; prog[2] = 8'h80; prog[3] = 8'h30;
        prog[4] = 8'h80; prog[5] = 8'h28; prog[6] = 8'h00; prog[7] = 8'hF0;
        pushSt(3'd0, 8'h00);
        pushInstr(8'h00, 4'h0, 1'b0, 1'b0);
        pushInstr(8'h02, 4'h0, 1'b1, 1'b1);
        pushInstr(8'h04, 4'h0, 1'b1, 1'b0);
        pushInstr(8'h06, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) pushSt(3'd5, 8'h08);
        runProgram(1'b1);
        checkEq("st_mem80", {8'd0, mem[8'h80]}, 16'h005A);
        checkEq("ld_r3", {8'd0, rf[2]}, 16'h005A);

        // Reset asserted between edges during the second instruction's F1
        clearProg();
        prog[0] = 8'h77; prog[1] = 8'h10; prog[2] = 8'h01; prog[3] = 8'h14;
        prog[4] = 8'h00; prog[5] = 8'hF0;
        pushSt(3'd0, 8'h00);
        pushInstr(8'h00, 4'h0, 1'b0, 1'b0);
        pushSt(3'd1, 8'h02);
        pushSt(3'd2, 8'h03);
        runProgram(1'b1);
        checkEq("pre_abort_r1", {8'd0, rf[0]}, 16'h0077);
        Reset = 1'b1;
        #1;
        checkEq("abort_state", {13'd0, State}, 16'h0000);
        checkEq("abort_halted", {15'd0, Halted}, 16'h0000);
        @(negedge Clock);
        Reset = 1'b0;
        for (int i = 0; i < 4; i++)
            checkEq($sformatf("abort_r%0d", i + 1), {8'd0, rf[i]}, 16'h0000);
        checkEq("abort_pc", {8'd0, pcR}, 16'h0000);
        pushSt(3'd0, 8'h00);
        pushInstr(8'h00, 4'h0, 1'b0, 1'b0);
        pushInstr(8'h02, 4'h0, 1'b0, 1'b0);
        pushInstr(8'h04, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) pushSt(3'd5, 8'h06);
        runProgram(1'b0);
        checkEq("restart_r1", {8'd0, rf[0]}, 16'h0077);
        checkEq("restart_r2", {8'd0, rf[1]}, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired sequencer that drives every control input of `ALUSystem`, forming the upstream stage that `CompleteSystem` instantiates alongside it. Each cycle it reads `IROut` and `ALUOutFlag`, steps through clear, fetch (two bytes), execute and halt states, and emits the register-file, ALU, address-register-file, IR, memory and mux selects. Datapath registers have no reset, so this block clears them after reset.

## Interface
- No parameters.
- `Clock` in 1: rising-edge clock.
- `Reset` in 1: asynchronous, active-high.
- `IROut` in 16: instruction register contents.
  - [15:12] opcode.
  - [11:10] RD.
  - [9:8] RS.
  - [7:0] imm/addr.
- `ALUOutFlag` in 4: ALU flags {Z,C,N,O}, bit 3 = Z.
- `RF_OutASel`, `RF_OutBSel` out 2 each: register select, 00=R1 … 11=R4.
- `RF_FunSel`, `ARF_FunSel`, `IR_Funsel` out 2 each: 00 decrement, 01 increment, 10 load, 11 clear.
- `RF_RegSel` out 4: active-low enables; bit3=R1 … bit0=R4.
- `ALU_FunSel` out 4: 0000 pass A, 0100 A+B, 0110 A−B.
- `ARF_OutCSel`, `ARF_OutDSel` out 2 each: 00 PC, 01 AR, 10 SP. D drives the memory address.
- `ARF_RegSel` out 3: active-low enables {PC,AR,SP}.
- `IR_LH` out 1: 0 loads IR[7:0], 1 loads IR[15:8].
- `IR_Enable` out 1.
- `Mem_WR` out 1: 1 write.
- `Mem_CS` out 1: active-low chip select.
- `MuxASel`, `MuxBSel` out 2 each: RF / ARF input source, 00 ALUOut, 01 MemoryOut, 10 IROut[7:0], 11 ARF_COut.
- `MuxCSel` out 1: ALU A input, 0 RF AOut, 1 ARF_COut.
- `Halted` out 1.
- `State` out 3: CLR=0, F0=1, F1=2, EX0=3, EX1=4, HALT=5.

## Operation
- **Idle vector.** Unless listed otherwise, outputs take these values:
  - RF_RegSel=1111, ARF_RegSel=111.
  - IR_Enable=0, Mem_CS=1, Mem_WR=0.
  - All FunSels 00, all other selects 0.
- **Internal state.** Internal Z copy `zf` resets to 0. It is updated from ALUOutFlag[3] only at the EX0 edge of ADD/SUB.
- **CLR.**
  - Outputs: RF_RegSel=0000, RF_FunSel=11, ARF_RegSel=000, ARF_FunSel=11.
  - Next state: F0.
- **F0.**
  - Outputs: ARF_OutDSel=00, Mem_CS=0, IR_Enable=1, IR_LH=0, IR_Funsel=10, ARF_RegSel=011, ARF_FunSel=01.
  - Effect: IR low byte ← M[PC], PC++.
  - Next state: F1.
- **F1.** Same as F0 with IR_LH=1. Next state: EX0.
- **EX0 / EX1.** Decoded from IROut[15:12]. Next state is F0 unless stated.
  - **0x0 NOP and undefined opcodes 0x8–0xE:** idle vector.
  - **0x1 LDI.** MuxASel=10, RF_FunSel=10, RF_RegSel=RD one-hot-low; RD ← imm.
  - **0x2 LD.**
    - EX0: AR ← imm via MuxBSel=10, ARF_FunSel=10, ARF_RegSel=101; next state EX1.
    - EX1: ARF_OutDSel=01, Mem_CS=0, MuxASel=01, RF_FunSel=10, RD enabled; RD ← M[AR].
  - **0x3 ST.**
    - EX0: AR ← imm, as in LD; next state EX1.
    - EX1: RF_OutASel=RS, MuxCSel=0, ALU_FunSel=0000, ARF_OutDSel=01, Mem_CS=0, Mem_WR=1; M[AR] ← RS.
  - **0x4 ADD / 0x5 SUB.** RF_OutASel=RD, RF_OutBSel=RS, MuxCSel=0, ALU_FunSel 0100 / 0110, MuxASel=00, RF_FunSel=10, RD enabled. RD ← RD±RS, and zf is latched.
  - **0x6 BRA.** MuxBSel=10, ARF_FunSel=10, ARF_RegSel=011; PC ← imm.
  - **0x7 BNE.** Acts as BRA when zf=0, otherwise idle.
  - **0xF HLT.** Idle vector; next state HALT.
- **HALT.** Idle vector, Halted=1. Stays in HALT until Reset.
- **Output decode.** Outputs are combinational from the state register, IROut and zf only. There is no combinational path from ALUOutFlag.

## Timing
- **While Reset is high:**
  - State=CLR immediately (asynchronous), zf=0, Halted=0.
  - The CLR vector is output, so every edge during reset clears PC, AR, SP and R1–R4.
- **First edge after Reset falls:** executes CLR, then enters F0.
- **Instruction latency:**
  - LD and ST: 4 cycles (F0, F1, EX0, EX1).
  - All other opcodes: 3 cycles.
  - PC advances by 2 per instruction (once in F0, once in F1), except where a branch overwrites it.
- **Reset mid-instruction:** aborts at once; the partial IR load is discarded.
- **Same-edge effects:** memory read is combinational, so F0/F1 load IR and increment PC on the same edge. A branch in EX0 overwrites the already-incremented PC.
- **Flag sampling:** BNE sees the zf value latched by the most recent ADD/SUB.
- **PC wrap:** the 8-bit PC wraps from 0xFF to 0x00 with no special handling.

## Test plan
- **LDI:** memory {0x05, 0x10} at address 0.
  - Required: R1=0x05 and PC=0x02 at the third edge after CLR.
  - Required: State sequence 0,1,2,3,1.
- **ADD:** program LDI R1 5; LDI R2 3; ADD R1,R2.
  - Required: R1=0x08, zf=0.
  - Required: ALU_FunSel=0100 only during ADD's EX0.
- **SUB and BNE:** program LDI R1 3; LDI R2 3; SUB R1,R2; BNE 0x00; BRA 0x20.
  - Required: R1=0, zf=1, and BNE is not taken (PC=0x08 after it).
  - Required: PC=0x20 after BRA.
- **ST / LD:** ST R1,[0x80] with R1=0x5A, then LD R3,[0x80].
  - Required: M[0x80]=0x5A and R3=0x5A.
  - Required: Mem_WR=1 only in ST's EX1; 4 cycles per instruction.
- **HLT:** execute HLT.
  - Required: Halted=1 and PC frozen for 10 cycles.
  - Required: RF_RegSel=1111, ARF_RegSel=111, Mem_CS=1.
- **Reset mid-instruction:** assert Reset between edges during F1.
  - Required: State=0 before the next edge.
  - Required: after release, R1–R4 and PC are 0 and fetch restarts at address 0.
